// File: rtl/coinc_acq_ctrl_if.sv
// Readout stream between the acquisition sequencer and its consumer.
// The master (sequencer) presents one pair count per beat.
// The slave accepts the beat with Out_ready.
interface coinc_acq_ctrl_if #(
    parameter int NBITS = 4,
    parameter int IDXW  = 4
);
    logic [NBITS-1:0] Out_data;
    logic [IDXW-1:0]  Out_idx;
    logic             Out_valid;
    logic             Out_ready;

    modport master (output Out_data, output Out_idx, output Out_valid, input Out_ready);
    modport slave  (input Out_data, input Out_idx, input Out_valid, output Out_ready);
endinterface

// File: rtl/coinc_acq_ctrl.sv
// Acquisition sequencer for the coincidence detector.
// One run does the following:
//   - clears the detector counters;
//   - gates the channels for Window cycles;
//   - waits FLUSH cycles for the detector pipeline to drain;
//   - snapshots all pair counts;
//   - streams the snapshot out one pair per valid/ready beat.
// Optional feature macro: COINC_AUTORUN_EN. When it is defined, a finished
// drain loops back to CLEAR with the latched window until Abort.
module coinc_acq_ctrl #(
    parameter  int NCHAN  = 6,
    parameter  int NBITS  = 4,
    parameter  int WBITS  = 16,
    parameter  int FLUSH  = 3,
    localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2,
    localparam int IDXW   = $clog2(NPAIRS)
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start,
    input  logic                    Abort,
    input  logic [WBITS-1:0]        Window,
    input  logic [NPAIRS*NBITS-1:0] Counts_in,
    output logic                    Det_rst_n,
    output logic                    Det_en,
    output logic                    Busy,
    output logic                    Done,
    coinc_acq_ctrl_if.master        out_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACQ,
        S_FLUSH,
        S_LATCH,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [WBITS-1:0] window_q, window_d;
    logic [WBITS-1:0] cnt_q, cnt_d;
    logic             det_rst_n_q, det_rst_n_d;
    logic             det_en_q, det_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    logic [NBITS-1:0] out_data_q, out_data_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic [NBITS-1:0] shadow_q [NPAIRS];
    logic [NBITS-1:0] shadow_d [NPAIRS];

    // Next-state and registered-output computation for the run sequencer.
    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        shadow_d    = shadow_q;

        case (state_q)
            S_IDLE: begin
                // A zero-length window is not a run: ignore it entirely.
                if (Start && (Window != '0)) begin
                    window_d = Window;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = window_q;
                state_d = S_ACQ;
            end
            S_ACQ: begin
                cnt_d = cnt_q - WBITS'(1);
                if (cnt_q == WBITS'(1)) begin
                    // The counter is reused for the pipeline flush wait.
                    cnt_d   = WBITS'(FLUSH);
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q - WBITS'(1);
                if (cnt_q == WBITS'(1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                for (int p = 0; p < NPAIRS; p++) begin
                    shadow_d[p] = Counts_in[p*NBITS +: NBITS];
                end
                out_idx_d = '0;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                if (!out_valid_q) begin
                    // First drain cycle: present pair 0.
                    out_valid_d = 1'b1;
                    out_data_d  = shadow_q[out_idx_q];
                end else if (out_if.Out_ready) begin
                    if (out_idx_q == IDXW'(NPAIRS - 1)) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
`ifdef COINC_AUTORUN_EN
                        state_d     = S_CLEAR;
`else
                        state_d     = S_IDLE;
`endif
                    end else begin
                        out_idx_d  = out_idx_q + IDXW'(1);
                        out_data_d = shadow_q[out_idx_q + IDXW'(1)];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a beat being accepted this cycle.
        if (Abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        det_rst_n_d = (state_q != S_CLEAR);
        det_en_d    = (state_q == S_ACQ) && !Abort;
        busy_d      = (state_d != S_IDLE);
    end

    // Control state and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            window_q    <= '0;
            cnt_q       <= '0;
            det_rst_n_q <= 1'b0;
            det_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            cnt_q       <= cnt_d;
            det_rst_n_q <= det_rst_n_d;
            det_en_q    <= det_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Snapshot storage; pure data, always rewritten in LATCH before use.
    always_ff @(posedge Clk) begin
        shadow_q <= shadow_d;
    end

    assign Det_rst_n        = det_rst_n_q;
    assign Det_en           = det_en_q;
    assign Busy             = busy_q;
    assign Done             = done_q;
    assign out_if.Out_valid = out_valid_q;
    assign out_if.Out_data  = out_data_q;
    assign out_if.Out_idx   = out_idx_q;
endmodule

// File: tb/tb_coinc_acq_ctrl.sv
// Self-checking bench for coinc_acq_ctrl.
// Each run is observed cycle by cycle and compared with the expected
// behaviour: gate timing from the Start edge, stream order, stall
// stability, Done, and Abort handling.
module tb_coinc_acq_ctrl;
    localparam int NCHAN  = 6;
    localparam int NBITS  = 4;
    localparam int WBITS  = 16;
    localparam int FLUSH  = 3;
    localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2;
    localparam int IDXW   = $clog2(NPAIRS);

    logic                    Clk = 1'b0;
    logic                    Rst_n = 1'b0;
    logic                    Start = 1'b0;
    logic                    Abort = 1'b0;
    logic [WBITS-1:0]        Window = '0;
    logic [NPAIRS*NBITS-1:0] Counts_in = '0;
    logic                    Det_rst_n, Det_en, Busy, Done;

    coinc_acq_ctrl_if #(.NBITS(NBITS), .IDXW(IDXW)) ifc ();

    coinc_acq_ctrl #(.NCHAN(NCHAN), .NBITS(NBITS), .WBITS(WBITS), .FLUSH(FLUSH)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Abort     (Abort),
        .Window    (Window),
        .Counts_in (Counts_in),
        .Det_rst_n (Det_rst_n),
        .Det_en    (Det_en),
        .Busy      (Busy),
        .Done      (Done),
        .out_if    (ifc.master)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [NBITS-1:0] exp_cnt [NPAIRS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a new set of detector counts and remember them as the expected snapshot.
    task automatic load_counts(input bit ramp);
        for (int p = 0; p < NPAIRS; p++) begin
            exp_cnt[p] = ramp ? NBITS'(p) : NBITS'($urandom);
            Counts_in[p*NBITS +: NBITS] = exp_cnt[p];
        end
    endtask

    // rmode: 0 = ready always, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
    task automatic run(input string nm, input int w, input int rmode, input int abort_n,
                       input bit abort_drain, input bit mid_start, input bit chg_counts);
        int rst_lo = 0, rst_first = -1, en_cnt = 0, en_first = -1;
        int fv = -1, done_cnt = 0, done_n = -1, last_beat_n = -1, stall_bad = 0;
        int end_n = -1, ab_n = -1, rdy_ctr = 0;
        int budget = w + FLUSH + 300;
        bit pv = 0, pr = 0, pa = 0, aborted = 0;
        logic [IDXW-1:0]  pidx = '0;
        logic [NBITS-1:0] pdata = '0;
        int bidx[$];
        int bdat[$];

        @(negedge Clk);
        Start  = 1'b1;
        Window = WBITS'(w);
        @(negedge Clk);
        Start  = 1'b0;
        // A window change mid-run must not affect the gate.
        Window = WBITS'($urandom_range(1, 40));
        for (int n = 0; n < budget; n++) begin
            if (!Det_rst_n) begin rst_lo++; if (rst_first < 0) rst_first = n; end
            if (Det_en) begin en_cnt++; if (en_first < 0) en_first = n; end
            if (Done) begin done_cnt++; if (done_n < 0) done_n = n; end
            if (pv && pr && !pa) begin
                bidx.push_back(int'(pidx));
                bdat.push_back(int'(pdata));
                last_beat_n = n;
            end
            if (pv && !pr && !pa &&
                !(ifc.Out_valid && ifc.Out_idx == pidx && ifc.Out_data == pdata)) stall_bad++;
            if (ifc.Out_valid && fv < 0) begin
                fv = n;
                if (chg_counts) Counts_in = (NPAIRS*NBITS)'({$urandom, $urandom});
            end
            if (aborted && n == ab_n + 1) begin
                chk({nm, "_abort_busy"}, Busy, 0);
                chk({nm, "_abort_valid"}, ifc.Out_valid, 0);
                chk({nm, "_abort_det_en"}, Det_en, 0);
            end
            if (end_n < 0 && (Done || aborted)) end_n = n;
            if (end_n >= 0 && n >= end_n + 3) break;

            // Drive inputs for the next rising edge.
            pv    = ifc.Out_valid;
            pidx  = ifc.Out_idx;
            pdata = ifc.Out_data;
            case (rmode)
                0:       pr = 1'b1;
                1:       pr = (rdy_ctr % 3 == 0);
                default: pr = 1'($urandom_range(0, 1));
            endcase
            rdy_ctr++;
            pa = 1'b0;
            if (!aborted) begin
                if (abort_n > 0 && n == abort_n) pa = 1'b1;
                if (abort_drain && ifc.Out_valid && ifc.Out_idx == IDXW'(7)) begin
                    pa = 1'b1;
                    pr = 1'b1;
                end
                if (pa) begin aborted = 1'b1; ab_n = n; end
            end
            ifc.Out_ready = pr;
            Abort         = pa;
            Start         = (mid_start && n == 4);
            if (mid_start && n == 4) Window = WBITS'(w + 5);
            if (chg_counts && n == w + 2) load_counts(1'b0);
            @(negedge Clk);
        end
        ifc.Out_ready = 1'b0;
        Abort = 1'b0;
        Start = 1'b0;

        chk({nm, "_finished_in_budget"}, (end_n >= 0), 1);
        if (!aborted) begin
            chk({nm, "_clear_cycles"}, rst_lo, 1);
            chk({nm, "_clear_at"}, rst_first, 1);
            chk({nm, "_gate_len"}, en_cnt, w);
            chk({nm, "_gate_start"}, en_first, 2);
            chk({nm, "_first_valid"}, fv, 3 + w + FLUSH);
            chk({nm, "_beats"}, bidx.size(), NPAIRS);
            for (int i = 0; i < bidx.size() && i < NPAIRS; i++) begin
                chk($sformatf("%s_idx%0d", nm, i), bidx[i], i);
                chk($sformatf("%s_data%0d", nm, i), bdat[i], int'(exp_cnt[i]));
            end
            chk({nm, "_done_cnt"}, done_cnt, 1);
            chk({nm, "_done_with_last"}, done_n, last_beat_n);
            if (rmode == 0) chk({nm, "_drain_len"}, done_n - fv, NPAIRS);
            chk({nm, "_stall_stable"}, stall_bad, 0);
            chk({nm, "_busy_end"}, Busy, 0);
        end else begin
            chk({nm, "_no_done"}, done_cnt, 0);
            chk({nm, "_beats_before_abort"}, bidx.size(), abort_drain ? 7 : 0);
            chk({nm, "_stall_stable"}, stall_bad, 0);
        end
        $display("run %s window=%0d rmode=%0d beats=%0d done=%0d aborted=%0d",
                 nm, w, rmode, bidx.size(), done_cnt, aborted);
    endtask

    initial begin
        int bad;
        ifc.Out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge Clk);
        chk("rst_det_rst_n", Det_rst_n, 0);
        chk("rst_det_en", Det_en, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_valid", ifc.Out_valid, 0);
        chk("rst_idx", ifc.Out_idx, 0);
        chk("rst_data", ifc.Out_data, 0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("det_rst_n_rise", Det_rst_n, 1);

`ifndef COINC_AUTORUN_EN
        // Basic run with a ramp of counts
        load_counts(1'b1);
        run("basic", 10, 0, 0, 0, 0, 0);

        // Stalled drain
        load_counts(1'b0);
        run("stall", $urandom_range(1, 8), 1, 0, 0, 0, 0);

        // Zero window is ignored
        @(negedge Clk);
        Start = 1'b1;
        Window = '0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Busy || !Det_rst_n || Done || ifc.Out_valid) bad++;
        end
        chk("zero_window_idle", bad, 0);

        // Start pulsed mid-ACQ; shortest window
        load_counts(1'b0);
        run("mid_start", 9, 0, 0, 0, 1, 0);
        run("min_window", 1, 0, 0, 0, 0, 0);

        // Abort during ACQ and during drain, each followed by a clean run
        run("abort_acq", 10, 0, 6, 0, 0, 0);
        load_counts(1'b0);
        run("after_abort_acq", 5, 0, 0, 0, 0, 0);
        run("abort_drain", 4, 0, 0, 1, 0, 0);
        load_counts(1'b0);
        run("after_abort_drain", 3, 2, 0, 0, 0, 0);

        // Counts change during flush and after the snapshot
        load_counts(1'b0);
        run("snapshot", 7, 2, 0, 0, 0, 1);

        // Randomised runs
        for (int r = 0; r < 4; r++) begin
            load_counts(1'b0);
            run($sformatf("rand%0d", r), $urandom_range(1, 12), $urandom_range(0, 2), 0, 0, 0, 0);
        end

        // Reset asserted mid-run
        @(negedge Clk);
        Start = 1'b1;
        Window = 16'd20;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("midrst_busy", Busy, 0);
        chk("midrst_det_en", Det_en, 0);
        chk("midrst_det_rst_n", Det_rst_n, 0);
        chk("midrst_valid", ifc.Out_valid, 0);
        chk("midrst_done", Done, 0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("midrst_release", Det_rst_n, 1);
        load_counts(1'b0);
        run("after_reset", 6, 0, 0, 0, 0, 0);
`else
        // Autorun: back-to-back runs, abort during the third drain
        begin
            int rst_lo = 0, done_cnt = 0, busy_gap = 0, ab_n = -1;
            load_counts(1'b1);
            ifc.Out_ready = 1'b1;
            @(negedge Clk);
            Start = 1'b1;
            Window = 16'd4;
            @(negedge Clk);
            Start = 1'b0;
            for (int n = 0; n < 400; n++) begin
                if (ab_n >= 0 && n == ab_n + 1) begin
                    chk("auto_abort_busy", Busy, 0);
                    chk("auto_abort_valid", ifc.Out_valid, 0);
                    break;
                end
                if (!Det_rst_n) rst_lo++;
                if (Done) done_cnt++;
                if (!Busy) busy_gap++;
                if (done_cnt == 2 && ifc.Out_valid && ifc.Out_idx == IDXW'(3)) begin
                    Abort = 1'b1;
                    ab_n = n;
                end
                @(negedge Clk);
            end
            Abort = 1'b0;
            ifc.Out_ready = 1'b0;
            chk("auto_aborted", (ab_n >= 0), 1);
            chk("auto_clear_pulses", rst_lo, 3);
            chk("auto_done_pulses", done_cnt, 2);
            chk("auto_busy_held", busy_gap, 0);
            $display("run autorun clears=%0d done=%0d", rst_lo, done_cnt);
        end
`endif

        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
